// File: rtl/turn_controller.sv
// Two-player turn sequencing for a battleship board: takes one shot per fire edge,
// scores it against the opponent's ship map, shows the result for HOLD_CYCLES, then hands over.
module turn_controller #(
  parameter int GRID_SIZE   = 10,
  parameter int HITS_TO_WIN = 17,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     fire,
  input  logic [$clog2(GRID_SIZE*GRID_SIZE)-1:0]   coord,
  input  logic [GRID_SIZE*GRID_SIZE-1:0]           ship_map_p0,
  input  logic [GRID_SIZE*GRID_SIZE-1:0]           ship_map_p1,
  output logic                                     active_player,
  output logic [GRID_SIZE*GRID_SIZE-1:0]           shot_map_p0,
  output logic [GRID_SIZE*GRID_SIZE-1:0]           shot_map_p1,
  output logic [GRID_SIZE*GRID_SIZE-1:0]           hit_map_p0,
  output logic [GRID_SIZE*GRID_SIZE-1:0]           hit_map_p1,
  output logic [$clog2(HITS_TO_WIN+1)-1:0]         hits_p0,
  output logic [$clog2(HITS_TO_WIN+1)-1:0]         hits_p1,
  output logic [1:0]                               last_result,
  output logic                                     result_valid,
  output logic                                     cursor_rst,
  output logic                                     game_over,
  output logic                                     winner
);

  localparam int CELLS = GRID_SIZE * GRID_SIZE;
  localparam int CW    = $clog2(CELLS);
  localparam int HW    = $clog2(HITS_TO_WIN + 1);
  localparam int TW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_MISS = 2'b01;
  localparam logic [1:0] RES_HIT  = 2'b10;
  localparam logic [1:0] RES_REJ  = 2'b11;

  typedef enum logic [2:0] {IDLE, EVAL, HOLD, SWITCH, OVER} state_t;

  state_t                    state, next_state;
  logic                      fire_q;
  logic [CW-1:0]             target;
  logic [TW-1:0]             hold_cnt;
  logic [1:0][CELLS-1:0]     shot_q, hit_q;
  logic [1:0][HW-1:0]        hits_q;

  logic                      fire_edge, opp, hold_done, already, is_hit, shot_ok, won;
  logic [CELLS-1:0]          tgt_mask, opp_ships;

  assign fire_edge = fire & ~fire_q;
  assign opp       = ~active_player;
  // Out-of-range targets shift the one-hot off the top and yield an all-zero mask.
  assign tgt_mask  = CELLS'(1) << target;
  assign opp_ships = opp ? ship_map_p1 : ship_map_p0;
  assign already   = |(tgt_mask & shot_q[opp]);
  assign is_hit    = |(tgt_mask & opp_ships);
  assign shot_ok   = (int'(target) < CELLS) && !already;
  assign hold_done = (hold_cnt == TW'(HOLD_CYCLES - 1));
  assign won       = (hits_q[active_player] == HW'(HITS_TO_WIN));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fire_edge) next_state = EVAL;
      EVAL:    next_state = shot_ok ? HOLD : IDLE;
      HOLD:    if (hold_done) next_state = won ? OVER : SWITCH;
      SWITCH:  next_state = IDLE;
      OVER:    next_state = OVER;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fire_q        <= 1'b0;
      target        <= '0;
      hold_cnt      <= '0;
      shot_q        <= '0;
      hit_q         <= '0;
      hits_q        <= '0;
      active_player <= 1'b0;
      last_result   <= RES_NONE;
      result_valid  <= 1'b0;
    end else begin
      fire_q <= fire;
      case (state)
        IDLE: if (fire_edge) target <= coord;
        EVAL: begin
          if (!shot_ok) begin
            last_result <= RES_REJ;
          end else begin
            shot_q[opp]  <= shot_q[opp] | tgt_mask;
            result_valid <= 1'b1;
            hold_cnt     <= '0;
            if (is_hit) begin
              hit_q[opp]  <= hit_q[opp] | tgt_mask;
              last_result <= RES_HIT;
              if (!won) hits_q[active_player] <= hits_q[active_player] + 1'b1;
            end else begin
              last_result <= RES_MISS;
            end
          end
        end
        HOLD: begin
          if (hold_done) begin
            result_valid <= 1'b0;
            hold_cnt     <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        SWITCH: begin
          active_player <= ~active_player;
          last_result   <= RES_NONE;
        end
        default: ;
      endcase
    end
  end

  assign shot_map_p0 = shot_q[0];
  assign shot_map_p1 = shot_q[1];
  assign hit_map_p0  = hit_q[0];
  assign hit_map_p1  = hit_q[1];
  assign hits_p0     = hits_q[0];
  assign hits_p1     = hits_q[1];
  // Cursor reset follows rst directly so it is high in every reset cycle.
  assign cursor_rst  = rst | (state == SWITCH);
  assign game_over   = (state == OVER);
  assign winner      = game_over & active_player;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: hit/miss/reject turns, held fire, full game to 17 hits,
// and reset in the middle of a result hold.
module tb_turn_controller;

  logic        clk = 1'b0;
  logic        rst, fire;
  logic [6:0]  coord;
  logic [99:0] ship_map_p0, ship_map_p1;
  logic        active_player, result_valid, cursor_rst, game_over, winner;
  logic [99:0] shot_map_p0, shot_map_p1, hit_map_p0, hit_map_p1;
  logic [4:0]  hits_p0, hits_p1;
  logic [1:0]  last_result;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [99:0] exp_shot [2];
  logic [99:0] exp_hit  [2];
  int          exp_hits [2];
  logic        exp_ap;

  turn_controller #(.GRID_SIZE(10), .HITS_TO_WIN(17), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .fire(fire), .coord(coord),
    .ship_map_p0(ship_map_p0), .ship_map_p1(ship_map_p1),
    .active_player(active_player),
    .shot_map_p0(shot_map_p0), .shot_map_p1(shot_map_p1),
    .hit_map_p0(hit_map_p0), .hit_map_p1(hit_map_p1),
    .hits_p0(hits_p0), .hits_p1(hits_p1),
    .last_result(last_result), .result_valid(result_valid),
    .cursor_rst(cursor_rst), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_maps(input string tag);
    chk({tag, ".shot0"}, shot_map_p0, exp_shot[0]);
    chk({tag, ".shot1"}, shot_map_p1, exp_shot[1]);
    chk({tag, ".hit0"},  hit_map_p0,  exp_hit[0]);
    chk({tag, ".hit1"},  hit_map_p1,  exp_hit[1]);
    chk({tag, ".hits0"}, hits_p0, exp_hits[0]);
    chk({tag, ".hits1"}, hits_p1, exp_hits[1]);
  endtask

  task automatic model_reset();
    exp_shot[0] = '0; exp_shot[1] = '0;
    exp_hit[0]  = '0; exp_hit[1]  = '0;
    exp_hits[0] = 0;  exp_hits[1] = 0;
    exp_ap = 1'b0;
  endtask

  // One turn: fire edge at cell c, expected result code given by hand.
  task automatic do_shot(input int c, input logic [1:0] exp_res, input bit hold_fire);
    int n;
    int opp;
    @(negedge clk); fire = 1'b1; coord = 7'(c);
    @(negedge clk); if (!hold_fire) fire = 1'b0;
    @(negedge clk);
    chk("result", last_result, exp_res);
    if (exp_res == 2'b11) begin
      chk("rej.cursor_rst", cursor_rst, 1'b0);
      chk_maps("rej");
      @(negedge clk);
      chk("rej.player", active_player, exp_ap);
      chk("rej.rv", result_valid, 1'b0);
      chk("rej.cursor_rst2", cursor_rst, 1'b0);
      return;
    end
    opp = exp_ap ? 0 : 1;
    exp_shot[opp][c] = 1'b1;
    if (exp_res == 2'b10) begin
      exp_hit[opp][c] = 1'b1;
      exp_hits[exp_ap]++;
    end
    chk("rv", result_valid, 1'b1);
    chk_maps("shot");
    n = 0;
    while (result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_len", n, 4);
    if (exp_hits[exp_ap] == 17) begin
      chk("over.game_over", game_over, 1'b1);
      chk("over.winner", winner, exp_ap);
      chk("over.cursor_rst", cursor_rst, 1'b0);
    end else begin
      chk("switch.cursor_rst", cursor_rst, 1'b1);
      chk("switch.player", active_player, exp_ap);
      @(negedge clk);
      exp_ap = ~exp_ap;
      chk("idle.player", active_player, exp_ap);
      chk("idle.result", last_result, 2'b00);
      chk("idle.cursor_rst", cursor_rst, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fire = 1'b0; coord = '0;
    ship_map_p0 = '0; ship_map_p1 = '0;
    for (int i = 20; i <= 36; i++) ship_map_p1[i] = 1'b1;
    for (int i = 50; i <= 66; i++) ship_map_p0[i] = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.cursor_rst", cursor_rst, 1'b1);
    chk_maps("rst");
    chk("rst.result", last_result, 2'b00);
    chk("rst.rv", result_valid, 1'b0);
    chk("rst.player", active_player, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.cursor_rst", cursor_rst, 1'b0);
    chk("post_rst.game_over", game_over, 1'b0);

    do_shot(23, 2'b10, 0);       // p0 hits p1 cell 23
    do_shot(5,  2'b01, 0);       // p1 misses p0 cell 5
    do_shot(24, 2'b10, 1);       // p0 hit, fire kept high afterwards
    repeat (4) @(negedge clk);
    chk("held.player", active_player, 1'b1);
    chk("held.rv", result_valid, 1'b0);
    chk_maps("held");
    fire = 1'b0;

    do_shot(5,   2'b11, 0);      // repeat cell
    do_shot(100, 2'b11, 0);      // off board
    do_shot(127, 2'b11, 0);
    do_shot(70,  2'b01, 0);

    for (int k = 0; k < 15; k++) begin
      do_shot((k < 12) ? 25 + k : 8 + k, 2'b10, 0);
      if (k < 14) do_shot(71 + k, 2'b01, 0);
    end

    // Game over: further fire edges are ignored
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); fire = 1'b1; coord = 7'(99 - k);
      @(negedge clk); fire = 1'b0;
    end
    repeat (8) @(negedge clk);
    chk_maps("over");
    chk("over.game_over2", game_over, 1'b1);
    chk("over.winner2", winner, 1'b0);
    chk("over.rv", result_valid, 1'b0);
    chk("over.player", active_player, 1'b0);

    // Reset mid-HOLD
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(negedge clk); fire = 1'b1; coord = 7'd40;
    @(negedge clk); fire = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midhold.rv", result_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("midhold.cursor_rst_async", cursor_rst, 1'b1);
    @(negedge clk);
    chk("midrst.cursor_rst", cursor_rst, 1'b1);
    chk_maps("midrst");
    chk("midrst.rv", result_valid, 1'b0);
    chk("midrst.result", last_result, 2'b00);
    chk("midrst.game_over", game_over, 1'b0);
    chk("midrst.player", active_player, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.cursor_rst_off", cursor_rst, 1'b0);
    repeat (6) @(negedge clk);
    chk("midrst.no_switch", active_player, 1'b0);
    chk("midrst.rv_idle", result_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 10, meaning board edge length; cells numbered 0..GRID_SIZE*GRID_SIZE-1, row-major.
REQ-002 SHALL have parameter HITS_TO_WIN, default 17, meaning hits a player needs to win.
REQ-003 SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning result display time in clk cycles; legal range >= 1.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on posedge clk.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port fire, input, 1, meaning debounced fire button, level.
REQ-007 SHALL have port coord, input, 7, meaning cursor cell of the active player.
REQ-008 SHALL have ports ship_map_p0 and ship_map_p1, input, 100 each, meaning bit i = 1 when that player's own ship occupies cell i.
REQ-009 SHALL have port active_player, output, 1, meaning player whose turn it is (0/1).
REQ-010 SHALL have ports shot_map_p0/p1, output, 100 each, meaning bit i = 1 when cell i of that player's board has been fired on.
REQ-011 SHALL have ports hit_map_p0/p1, output, 100 each, meaning bit i = 1 when that shot hit a ship.
REQ-012 SHALL have ports hits_p0/p1, output, 5 each, meaning hits scored BY that player.
REQ-013 SHALL have port last_result, output, 2, meaning 00 none, 01 miss, 10 hit, 11 rejected.
REQ-014 SHALL have port result_valid, output, 1, meaning high while a miss/hit result is displayed.
REQ-015 SHALL have port cursor_rst, output, 1, meaning one-cycle pulse driving the cursor's address reset.
REQ-016 SHALL have ports game_over, output, 1, and winner, output, 1.

Function
REQ-017 SHALL register fire into fire_q every cycle in all states; fire edge = fire & ~fire_q.
REQ-018 SHALL implement FSM states IDLE, EVAL, HOLD, SWITCH, OVER.
REQ-019 IDLE: on fire edge SHALL latch coord into target and go EVAL; edges in any other state SHALL be ignored and never queued.
REQ-020 Target board SHALL be the opponent's (~active_player) board.
REQ-021 EVAL (one cycle): if target >= GRID_SIZE*GRID_SIZE or target cell already in the target board's shot_map, SHALL set last_result=11, leave maps/counts/player unchanged, and return to IDLE.
REQ-022 EVAL otherwise SHALL set the shot_map bit, set the hit_map bit and last_result=10 when the opponent's ship_map bit is 1, else last_result=01, and go HOLD.
REQ-023 On hit, the active player's hit count SHALL increment by 1, saturating at HITS_TO_WIN.
REQ-024 HOLD: result_valid=1; SHALL count exactly HOLD_CYCLES cycles, then go OVER if the active player's count == HITS_TO_WIN, else go SWITCH.
REQ-025 SWITCH (one cycle): SHALL toggle active_player, assert cursor_rst=1 for that cycle, and set last_result=00 and go IDLE.
REQ-026 OVER: game_over=1, winner=player reaching HITS_TO_WIN, result_valid=0; all inputs ignored until rst.
REQ-027 Fire-edge-to-map-update latency SHALL be 2 clk edges (latch edge, EVAL edge); outputs registered.
REQ-028 ship_map inputs SHALL be sampled only in EVAL; changes at other times have no effect.
REQ-029 cursor_rst SHALL be 0 in all states except SWITCH and the reset cycle.

Reset
REQ-030 rst SHALL override all activity in any state, including mid-HOLD.
REQ-031 On rst: state=IDLE, active_player=0, all shot/hit maps=0, hits=0, last_result=00, result_valid=0, game_over=0, winner=0, hold counter=0, fire_q=0.
REQ-032 cursor_rst SHALL be 1 during every cycle rst is high and 0 on the first cycle after.

Verification
REQ-033 Reset, ship_map_p1 bit 23=1, coord=23, fire edge -> 2 edges later shot_map_p1[23]=1, hit_map_p1[23]=1, hits_p0=1, last_result=10, result_valid=1.
REQ-034 HOLD_CYCLES=4, miss at coord=5 -> result_valid high exactly 4 cycles, then one-cycle cursor_rst, active_player=1, last_result=00.
REQ-035 Repeat shot at an already-fired cell, or coord=100 -> last_result=11, no map/count change, no cursor_rst, active_player unchanged.
REQ-036 fire held high through HOLD and SWITCH -> no second shot; next shot requires a fresh 0->1 fire transition.
REQ-037 Player 0 scores 17 hits (p1 interleaving misses) -> after final hold game_over=1, winner=0; further fire edges change nothing.
REQ-038 rst asserted mid-HOLD -> next cycle all outputs at reset values and cursor_rst=1 during rst.
